// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter sharing one 2:1 data mux and one output
// register; grants are capped at BURST_MAX consecutive transfers per owner.
//
// state | meaning
// IDLE  | no owner; next grant goes to the lone requester, or on a tie to the
//       | requester that was not served last
// OWN_A | A was granted last; A keeps the slot until its burst is used up
// OWN_B | B was granted last; B keeps the slot until its burst is used up
module rr_mux_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] a_data_in,
  output logic              a_ready_out,
  input  logic              b_valid_in,
  input  logic [DATA_W-1:0] b_data_in,
  output logic              b_ready_out,
  output logic              out_valid_out,
  output logic [DATA_W-1:0] out_data_out,
  output logic              out_src_out,
  input  logic              out_ready_in,
  output logic              busy_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  state_t     state;
  logic [7:0] burst_cnt;
  logic       last_src;
  logic       slot_free;
  logic       pick_a;
  logic       grant_a;
  logic       grant_b;
  logic       same_owner;

  // pick_a is only meaningful when at least one requester is valid
  always_comb begin
    slot_free = !out_valid_out || out_ready_in;
    pick_a    = 1'b0;
    case (state)
      OWN_A:   pick_a = a_valid_in && (!b_valid_in || (burst_cnt < BURST_LIM));
      OWN_B:   pick_a = a_valid_in && !(b_valid_in && (burst_cnt < BURST_LIM));
      default: pick_a = a_valid_in && (!b_valid_in || last_src);
    endcase
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && slot_free && (a_valid_in || b_valid_in)) begin
      grant_a = pick_a;
      grant_b = !pick_a;
    end
  end

  assign a_ready_out = grant_a;
  assign b_ready_out = grant_b;
  assign same_owner  = (grant_a && state == OWN_A) || (grant_b && state == OWN_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      burst_cnt     <= 8'd0;
      last_src      <= 1'b1;
      out_valid_out <= 1'b0;
      out_data_out  <= '0;
      out_src_out   <= 1'b0;
      busy_out      <= 1'b0;
    end else if (grant_a || grant_b) begin
      state         <= grant_a ? OWN_A : OWN_B;
      last_src      <= grant_b;
      out_valid_out <= 1'b1;
      out_data_out  <= grant_a ? a_data_in : b_data_in;
      out_src_out   <= grant_b;
      busy_out      <= 1'b1;
      if (!same_owner)
        burst_cnt <= 8'd1;
      else if (burst_cnt < BURST_LIM)
        burst_cnt <= burst_cnt + 8'd1;
    end else if (slot_free) begin
      // free slot with no grant means nobody is requesting
      state         <= IDLE;
      busy_out      <= 1'b0;
      out_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus random traffic, all
// checked against a request/owner/run-length model of the arbitration rules.
module tb_rr_mux_arbiter;

  localparam int BMAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;

  logic       a_ready, b_ready, out_valid, out_src, busy;
  logic [7:0] out_data;
  logic       a_ready1, b_ready1, out_valid1, out_src1, busy1;
  logic [7:0] out_data1;

  int n_checks = 0;
  int n_errors = 0;

  // model: owner 0 = none, 1 = A, 2 = B
  int         m_owner, m_run, m_last, m_g;
  logic       m_ov, m_os, m_busy, e_ga, e_gb;
  logic [7:0] m_od;
  logic [12:0] exp_vec;
  logic [12:0] dut_vec;
  logic [12:0] dut1_vec;

  assign dut_vec  = {a_ready, b_ready, out_valid, out_data, out_src, busy};
  assign dut1_vec = {a_ready1, b_ready1, out_valid1, out_data1, out_src1, busy1};

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DATA_W(8), .BURST_MAX(BMAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid_in(a_valid), .a_data_in(a_data), .a_ready_out(a_ready),
    .b_valid_in(b_valid), .b_data_in(b_data), .b_ready_out(b_ready),
    .out_valid_out(out_valid), .out_data_out(out_data), .out_src_out(out_src),
    .out_ready_in(out_ready), .busy_out(busy)
  );

  rr_mux_arbiter #(.DATA_W(8), .BURST_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid_in(a_valid), .a_data_in(a_data), .a_ready_out(a_ready1),
    .b_valid_in(b_valid), .b_data_in(b_data), .b_ready_out(b_ready1),
    .out_valid_out(out_valid1), .out_data_out(out_data1), .out_src_out(out_src1),
    .out_ready_in(out_ready), .busy_out(busy1)
  );

  task automatic model_reset();
    m_owner = 0; m_run = 0; m_last = 2;
    m_ov = 1'b0; m_od = 8'h00; m_os = 1'b0; m_busy = 1'b0;
    e_ga = 1'b0; e_gb = 1'b0; m_g = 0;
    exp_vec = '0;
  endtask

  // who is served this cycle, from the current requests and model history
  task automatic model_eval();
    bit sf;
    sf  = !m_ov || out_ready;
    m_g = 0;
    if (rst_n && sf) begin
      if (a_valid && !b_valid)      m_g = 1;
      else if (b_valid && !a_valid) m_g = 2;
      else if (a_valid && b_valid) begin
        if (m_owner == 0)       m_g = 3 - m_last;
        else if (m_run < BMAX)  m_g = m_owner;
        else                    m_g = 3 - m_owner;
      end
    end
    e_ga = (m_g == 1);
    e_gb = (m_g == 2);
    exp_vec = {e_ga, e_gb, m_ov, m_od, m_os, m_busy};
  endtask

  task automatic model_commit();
    bit sf;
    sf = !m_ov || out_ready;
    if (!rst_n) begin
      model_reset();
    end else if (m_g != 0) begin
      m_run   = (m_g == m_owner) ? ((m_run + 1 > BMAX) ? BMAX : m_run + 1) : 1;
      m_owner = m_g;
      m_last  = m_g;
      m_ov    = 1'b1;
      m_od    = (m_g == 1) ? a_data : b_data;
      m_os    = (m_g == 2);
    end else if (sf) begin
      m_owner = 0;
      m_ov    = 1'b0;
    end
    m_busy = (m_owner != 0);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      a_data = 8'($urandom); b_data = 8'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== 13'h0 || dut1_vec !== 13'h0) begin
        $display("FAIL reset_outputs: got %h/%h exp 0000", dut_vec, dut1_vec);
        n_errors++;
      end
      @(posedge clk); #1;
    end
    model_reset();
    rst_n = 1'b1; a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      $display("FAIL reset_first_ready: got %b exp 10", {a_ready, b_ready});
      n_errors++;
    end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_data, out_src} !== {1'b1, 8'h11, 1'b0}) begin
      $display("FAIL reset_first_word: got %b %h %b exp 1 11 0", out_valid, out_data, out_src);
      n_errors++;
    end
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1; b_valid = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      a_valid = (i < 8);
      a_data  = 8'(8'h10 + i);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (dut_vec !== exp_vec) begin
        $display("FAIL stream_model: got %h exp %h", dut_vec, exp_vec);
        n_errors++;
      end
      if (i > 0) begin
        n_checks++;
        if ({out_valid, out_data, out_src, busy} !== {1'b1, 8'(8'h0F + i), 1'b0, 1'b1}) begin
          $display("FAIL stream_word: got %b %h %b %b exp 1 %h 0 1",
                   out_valid, out_data, out_src, busy, 8'(8'h0F + i));
          n_errors++;
        end
      end
      tick();
    end
    a_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp0 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'hBB; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      model_eval();
      n_checks++;
      if (dut_vec !== exp_vec) begin
        $display("FAIL rr_model: got %h exp %h", dut_vec, exp_vec);
        n_errors++;
      end
      n_checks++;
      if ({out_valid, out_src, out_data} !== {1'b1, exp0[k], (exp0[k] ? 8'hBB : 8'hAA)}) begin
        $display("FAIL rr_burst4_src[%0d]: got %b %b %h exp 1 %b", k, out_valid, out_src, out_data, exp0[k]);
        n_errors++;
      end
      n_checks++;
      if ({out_valid1, out_src1} !== {1'b1, 1'(k % 2)}) begin
        $display("FAIL rr_burst1_src[%0d]: got %b %b exp 1 %0d", k, out_valid1, out_src1, k % 2);
        n_errors++;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b0; out_ready = 1'b1;
    tick();
    a_data = 8'h66; b_valid = 1'b1; b_data = 8'h77; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({a_ready, b_ready, out_valid, out_data} !== {2'b00, 1'b1, 8'h5A} || dut_vec !== exp_vec) begin
        $display("FAIL bp_hold[%0d]: got %h exp %h", i, dut_vec, exp_vec);
        n_errors++;
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      $display("FAIL bp_release_ready: got %b exp 10", {a_ready, b_ready});
      n_errors++;
    end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_data, out_src} !== {1'b1, 8'h66, 1'b0}) begin
      $display("FAIL bp_reload: got %b %h %b exp 1 66 0", out_valid, out_data, out_src);
      n_errors++;
    end
    tick();
    b_valid = 1'b0;
    tick();
  endtask

  task automatic test_owner_switch();
    do_reset();
    out_ready = 1'b1; b_valid = 1'b0; a_valid = 1'b1;
    a_data = 8'h21; tick();
    a_data = 8'h22; tick();
    a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h31;
    @(negedge clk);
    n_checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      $display("FAIL sw_ready: got %b exp 01", {a_ready, b_ready});
      n_errors++;
    end
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_data, out_src, u_dut.burst_cnt} !== {1'b1, 8'h31, 1'b1, 8'd1}) begin
      $display("FAIL sw_word: got %b %h %b cnt %0d exp 1 31 1 cnt 1",
               out_valid, out_data, out_src, u_dut.burst_cnt);
      n_errors++;
    end
    tick();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h41; b_data = 8'h42;
    @(negedge clk);
    model_eval();
    n_checks++;
    if ({busy, a_ready, b_ready} !== 3'b010 || dut_vec !== exp_vec) begin
      $display("FAIL sw_idle_tie: got busy %b ready %b exp busy 0 ready 10", busy, {a_ready, b_ready});
      n_errors++;
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_data, out_src} !== {8'h41, 1'b0}) begin
      $display("FAIL sw_tie_word: got %h %b exp 41 0", out_data, out_src);
      n_errors++;
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h81; b_data = 8'h82; out_ready = 1'b1;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, a_ready, b_ready} !== 3'b000) begin
      $display("FAIL async_reset: got valid %b ready %b exp 0 00", out_valid, {a_ready, b_ready});
      n_errors++;
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    model_eval();
    n_checks++;
    if ({a_ready, b_ready} !== 2'b10 || dut_vec !== exp_vec) begin
      $display("FAIL async_first_grant: got %h exp %h", dut_vec, exp_vec);
      n_errors++;
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!a_valid || e_ga) begin a_valid = ($urandom_range(0, 3) != 0); a_data = 8'($urandom); end
      if (!b_valid || e_gb) begin b_valid = ($urandom_range(0, 3) != 0); b_data = 8'($urandom); end
      out_ready = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (dut_vec !== exp_vec) begin
        $display("FAIL random_model[%0d]: got %h exp %h", i, dut_vec, exp_vec);
        n_errors++;
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_round_robin();
    test_backpressure();
    test_owner_switch();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
